// File: rtl/load_store_unit.sv
// Load/store initiator for the word-wide memory system: sub-word extraction,
// read-modify-write for sb/sh, stall-bounded handshake with timeout fault.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StRmwRd, StRmwWr, StDone} state_e;

  state_e           state_q;
  logic [31:0]      addr_q, wdata_q, merge_q, rdata_q;
  logic [2:0]       funct3_q;
  logic             we_q, fault_q;
  logic [CNT_W-1:0] cnt_q;

  logic        legal, aligned, in_mem, timeout;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val, merged;

  always_comb begin
    if (req_we) legal = funct3 inside {3'b000, 3'b001, 3'b010};
    else        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  assign in_mem  = state_q inside {StRead, StWrite, StRmwRd, StRmwWr};
  // The stall seen on the MAX_WAIT-th consecutive stalled cycle abandons the access.
  assign timeout = in_mem && mem_stall && (cnt_q == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            we_q     <= req_we;
            cnt_q    <= '0;
            if (!legal || !aligned) begin
              fault_q <= 1'b1;
              state_q <= StDone;
            end else begin
              fault_q <= 1'b0;
              if (!req_we)        state_q <= StRead;
              else if (funct3[1]) state_q <= StWrite;
              else                state_q <= StRmwRd;
            end
          end
        end
        StRead: if (!mem_stall) begin
          rdata_q <= load_val;
          state_q <= StDone;
          cnt_q   <= '0;
        end
        StWrite: if (!mem_stall) begin
          state_q <= StDone;
          cnt_q   <= '0;
        end
        StRmwRd: if (!mem_stall) begin
          merge_q <= mem_rdata;
          state_q <= StRmwWr;
          cnt_q   <= '0;
        end
        StRmwWr: if (!mem_stall) begin
          state_q <= StDone;
          cnt_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
      if (timeout) begin
        state_q <= StDone;
        fault_q <= 1'b1;
        cnt_q   <= '0;
      end else if (in_mem && mem_stall) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy        = (state_q == StIdle) ? req_valid : (state_q != StDone);
    mem_read    = (state_q == StRead) || (state_q == StRmwRd);
    mem_write   = (state_q == StWrite) || (state_q == StRmwWr);
    mem_addr    = {addr_q[31:2], 2'b00};
    rdata       = rdata_q;
    rdata_valid = (state_q == StDone) && !fault_q && !we_q;
    fault       = (state_q == StDone) && fault_q;
    case (state_q)
      StWrite: mem_wdata = wdata_q;
      StRmwWr: mem_wdata = merged;
      default: mem_wdata = '0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random requests against a
// byte-arithmetic reference model and an emulated stalling memory.
module tb_load_store_unit;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, mem_stall;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, rdata_valid, fault, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [128];
  logic [31:0] exp_rdata;

  bit          r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_wd;
  int unsigned r_st;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid),
    .fault(fault), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    bit legal;
    n = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return !legal || (a % n != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int unsigned n, sh;
    logic [63:0] v;
    n  = 1 << f3[1:0];
    sh = 8 * (a % 4);
    v  = {32'h0, word} >> sh;
    if (n < 4) v = v & ((64'd1 << (8 * n)) - 64'd1);
    if (f3 < 3'd4 && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] old, input logic [31:0] wd);
    int unsigned n, sh;
    logic [63:0] mask, ins;
    n    = 1 << f3[1:0];
    sh   = 8 * (a % 4);
    mask = ((64'd1 << (8 * n)) - 64'd1) << sh;
    ins  = ({32'h0, wd} << sh) & mask;
    return (old & ~mask[31:0]) | ins[31:0];
  endfunction

  // One request; the emulated memory stalls each access for `stalls` cycles.
  task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int unsigned stalls, input string tag);
    bit          flt, to, exp_rv, done, stall;
    int          acc_n, exp_cycles, exp_rd, exp_wr, exp_wcomp, len;
    int          cyc, rd, wr, both, rv, ft, abad, wcomp, run;
    bit          acc_w [2];
    logic [1:0]  kind, prev;
    logic [31:0] word, exp_w;

    flt        = model_fault(we, f3, a);
    word       = mem[a[8:2]];
    acc_n      = flt ? 0 : (!we ? 1 : (f3 == 3'd2 ? 1 : 2));
    acc_w[0]   = we && (f3 == 3'd2);
    acc_w[1]   = 1'b1;
    to         = 1'b0;
    exp_cycles = 2;
    exp_rd     = 0;
    exp_wr     = 0;
    exp_wcomp  = 0;
    for (int i = 0; i < acc_n && !to; i++) begin
      len = (stalls >= MW) ? MW : stalls + 1;
      if (acc_w[i]) exp_wr += len;
      else          exp_rd += len;
      exp_cycles += len;
      if (stalls >= MW) to = 1'b1;
      else if (acc_w[i]) exp_wcomp = 1;
    end
    exp_rv = !we && !flt && !to;
    if (exp_rv) exp_rdata = model_load(f3, a, word);
    exp_w = (we && f3 == 3'd2) ? wd : model_store(f3, a, word, wd);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    mem_stall = 1'b0;
    cyc = 0; rd = 0; wr = 0; both = 0; rv = 0; ft = 0; abad = 0; wcomp = 0; run = 0;
    done = 1'b0;
    prev = 2'b00;
    while (!done && cyc < 60) begin
      #1;
      cyc++;
      kind = {mem_read, mem_write};
      if (kind != 2'b00) begin
        if (kind == prev) run++;
        else run = 0;
        if (mem_addr !== {a[31:2], 2'b00}) abad++;
      end
      prev      = kind;
      stall     = (kind != 2'b00) && (run < stalls);
      mem_stall = stall;
      mem_rdata = mem[mem_addr[8:2]];
      if (mem_read) rd++;
      if (mem_write) wr++;
      if (mem_read && mem_write) both++;
      if (rdata_valid) rv++;
      if (fault) ft++;
      if (mem_write && !stall) begin
        wcomp++;
        check({tag, " wdata"}, mem_wdata, exp_w);
        mem[a[8:2]] = exp_w;
      end
      if (!busy) begin
        done = 1'b1;
        check({tag, " rdata"}, rdata, exp_rdata);
      end else begin
        @(negedge clk);
      end
    end
    check1({tag, " done"}, done, 1'b1);
    check({tag, " cycles"}, cyc, exp_cycles);
    check({tag, " reads"}, rd, exp_rd);
    check({tag, " writes"}, wr, exp_wr);
    check({tag, " rd_wr_overlap"}, both, 0);
    check({tag, " addr_unstable"}, abad, 0);
    check({tag, " write_done"}, wcomp, exp_wcomp);
    check({tag, " rvalid_pulses"}, rv, exp_rv ? 1 : 0);
    check({tag, " fault_pulses"}, ft, (flt || to) ? 1 : 0);
    @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b0;
    addr = '0; wdata = '0; mem_stall = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[16] = 32'h8899AABB;
    mem[32] = 32'h11223344;
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst busy", busy, 1'b0);
    check("rst rdata", rdata, 32'h0);
    check1("rst rdata_valid", rdata_valid, 1'b0);
    check1("rst fault", fault, 1'b0);
    check1("rst mem_read", mem_read, 1'b0);
    check1("rst mem_write", mem_write, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    req_valid = 1'b1;
    #1 check1("rst busy follows req", busy, 1'b1);
    req_valid = 1'b0;
    reset = 1'b0;

    xact(1'b0, 3'b000, 32'h41, 32'h0, 0, "lb41");
    check("lb41 value", rdata, 32'hFFFFFFAA);
    xact(1'b0, 3'b101, 32'h42, 32'h0, 0, "lhu42");
    check("lhu42 value", rdata, 32'h00008899);
    xact(1'b0, 3'b010, 32'h40, 32'h0, 3, "lw40_stall3");
    check("lw40 value", rdata, 32'h8899AABB);
    xact(1'b1, 3'b000, 32'h82, 32'h000000EE, 0, "sb82");
    check("sb82 rdata kept", rdata, 32'h8899AABB);
    xact(1'b0, 3'b000, 32'h82, 32'h0, 0, "lb82");
    check("lb82 merged byte", rdata, 32'hFFFFFFEE);
    xact(1'b0, 3'b010, 32'h102, 32'h0, 0, "lw_misaligned");
    xact(1'b0, 3'b011, 32'h40, 32'h0, 0, "ld_illegal");
    xact(1'b1, 3'b001, 32'h41, 32'h1234, 0, "sh_misaligned");
    xact(1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 100, "sw_timeout");
    xact(1'b0, 3'b010, 32'h44, 32'h0, 0, "lw_after_timeout");
    xact(1'b0, 3'b000, 32'h40, 32'h0, 100, "lb_timeout");
    xact(1'b1, 3'b001, 32'h86, 32'hCAFE, 2, "sh86_stall2");
    xact(1'b0, 3'b001, 32'h86, 32'h0, 0, "lh86");
    check("lh86 value", rdata, 32'hFFFFCAFE);

    // Reset while RMW_WR is held by a stalled memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b001; addr = 32'h84; wdata = 32'h5A5A;
    mem_stall = 1'b0; mem_rdata = mem[33];
    @(negedge clk);
    #1 check1("rmw rd phase", mem_read, 1'b1);
    mem_stall = 1'b0; mem_rdata = mem[33];
    @(negedge clk);
    #1 check1("rmw wr phase", mem_write, 1'b1);
    mem_stall = 1'b1; reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    #1 check1("rst mid mem_write", mem_write, 1'b0);
    check1("rst mid mem_read", mem_read, 1'b0);
    check1("rst mid fault", fault, 1'b0);
    check1("rst mid busy", busy, 1'b0);
    check("rst mid rdata", rdata, 32'h0);
    req_valid = 1'b1;
    #1 check1("rst mid idle", busy, 1'b1);
    req_valid = 1'b0; reset = 1'b0; mem_stall = 1'b0;
    exp_rdata = '0;
    xact(1'b0, 3'b010, 32'h84, 32'h0, 0, "lw84_after_reset");

    for (int i = 0; i < 150; i++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_we)                 r_f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: r_f3 = 3'b000;
          1: r_f3 = 3'b001;
          2: r_f3 = 3'b010;
          3: r_f3 = 3'b100;
          default: r_f3 = 3'b101;
        endcase
      end
      r_a = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) r_a = r_a & ~((32'd1 << r_f3[1:0]) - 32'd1);
      r_wd = $urandom;
      r_st = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      xact(r_we, r_f3, r_a, r_wd, r_st, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
